// File: rtl/paper_vtc.sv
// paper_vtc: video timing controller for the paper HDMI path (pixel clock domain).
// Generates programmable HSync/VSync/DE and pulls pixels from the pixel FIFO
// with a valid/ready handshake. It drives registered RGB/sync/DE to the TMDS
// encoder with one cycle of latency, and tracks FIFO underflow for the register block.
// Ports:
//   clk_i, rst_ni          pixel clock, async active-low reset
//   enable_i               level-sensitive run request
//   h_*_i / v_*_i          timing fields (pixels / lines), latched at frame start
//   pix_valid_i/pix_data_i FIFO side; pix_ready_o consumes when valid
//   rgb_o, de_o, hsync_o, vsync_o, frame_start_o   registered encoder outputs
//   busy_o                 in RUN; cfg_err_o: combinational timing legality
//   clr_stat_i             clears underflow_o / uf_cnt_o (wins over a new event)
module paper_vtc #(
    parameter int unsigned CntWidth   = 12,
    parameter logic        HSyncPol   = 1'b1,
    parameter logic        VSyncPol   = 1'b1,
    parameter int unsigned UfCntWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [CntWidth-1:0]   h_active_i,
    input  logic [CntWidth-1:0]   h_fp_i,
    input  logic [CntWidth-1:0]   h_sync_i,
    input  logic [CntWidth-1:0]   h_bp_i,
    input  logic [CntWidth-1:0]   v_active_i,
    input  logic [CntWidth-1:0]   v_fp_i,
    input  logic [CntWidth-1:0]   v_sync_i,
    input  logic [CntWidth-1:0]   v_bp_i,
    input  logic                  pix_valid_i,
    input  logic [23:0]           pix_data_i,
    output logic                  pix_ready_o,
    output logic [23:0]           rgb_o,
    output logic                  de_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  frame_start_o,
    output logic                  busy_o,
    output logic                  cfg_err_o,
    input  logic                  clr_stat_i,
    output logic                  underflow_o,
    output logic [UfCntWidth-1:0] uf_cnt_o
);
    // Totals of four fields need two extra bits; counters share that width so
    // they can never alias below the total.
    localparam int unsigned SumWidth = CntWidth + 2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [SumWidth-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                load;

    logic [CntWidth-1:0] h_act_q, h_fp_q, h_sync_q, h_bp_q;
    logic [CntWidth-1:0] v_act_q, v_fp_q, v_sync_q, v_bp_q;

    logic [SumWidth-1:0] hs_beg, hs_end, h_tot, vs_beg, vs_end, v_tot;
    logic                h_last, v_last, active, hs, vs, uf_event;

    assign cfg_err_o = (h_active_i == '0) | (h_sync_i == '0) |
                       (v_active_i == '0) | (v_sync_i == '0);

    // Region boundaries from the shadow copy of the timing.
    assign hs_beg = SumWidth'(h_act_q) + SumWidth'(h_fp_q);
    assign hs_end = hs_beg + SumWidth'(h_sync_q);
    assign h_tot  = hs_end + SumWidth'(h_bp_q);
    assign vs_beg = SumWidth'(v_act_q) + SumWidth'(v_fp_q);
    assign vs_end = vs_beg + SumWidth'(v_sync_q);
    assign v_tot  = vs_end + SumWidth'(v_bp_q);

    assign h_last = (h_cnt_q == h_tot - SumWidth'(1));
    assign v_last = (v_cnt_q == v_tot - SumWidth'(1));
    assign active = (h_cnt_q < SumWidth'(h_act_q)) & (v_cnt_q < SumWidth'(v_act_q));
    assign hs     = (h_cnt_q >= hs_beg) & (h_cnt_q < hs_end);
    assign vs     = (v_cnt_q >= vs_beg) & (v_cnt_q < vs_end);

    assign pix_ready_o = (state_q == RUN) & active;
    assign uf_event    = pix_ready_o & ~pix_valid_i;

    // State register and raster counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Next state / counter advance; shadows reload only at frame boundaries.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && !cfg_err_o) begin
                    load    = 1'b1;
                    state_d = RUN;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end
            end
            RUN: begin
                if (!h_last) begin
                    h_cnt_d = h_cnt_q + SumWidth'(1);
                end else begin
                    h_cnt_d = '0;
                    if (!v_last) begin
                        v_cnt_d = v_cnt_q + SumWidth'(1);
                    end else begin
                        v_cnt_d = '0;
                        if (enable_i && !cfg_err_o) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow timing registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_act_q  <= '0;
            h_fp_q   <= '0;
            h_sync_q <= '0;
            h_bp_q   <= '0;
            v_act_q  <= '0;
            v_fp_q   <= '0;
            v_sync_q <= '0;
            v_bp_q   <= '0;
        end else if (load) begin
            h_act_q  <= h_active_i;
            h_fp_q   <= h_fp_i;
            h_sync_q <= h_sync_i;
            h_bp_q   <= h_bp_i;
            v_act_q  <= v_active_i;
            v_fp_q   <= v_fp_i;
            v_sync_q <= v_sync_i;
            v_bp_q   <= v_bp_i;
        end
    end

    // Encoder-facing outputs, one cycle behind the counter position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o         <= '0;
            de_o          <= 1'b0;
            hsync_o       <= ~HSyncPol;
            vsync_o       <= ~VSyncPol;
            frame_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            busy_o <= (state_d == RUN);
            if (state_q == RUN) begin
                de_o          <= active;
                hsync_o       <= hs ? HSyncPol : ~HSyncPol;
                vsync_o       <= vs ? VSyncPol : ~VSyncPol;
                rgb_o         <= (active && pix_valid_i) ? pix_data_i : '0;
                frame_start_o <= (h_cnt_q == '0) && (v_cnt_q == '0);
            end else begin
                de_o          <= 1'b0;
                hsync_o       <= ~HSyncPol;
                vsync_o       <= ~VSyncPol;
                rgb_o         <= '0;
                frame_start_o <= 1'b0;
            end
        end
    end

    // Underflow status: sticky flag plus saturating count; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_o <= 1'b0;
            uf_cnt_o    <= '0;
        end else if (clr_stat_i) begin
            underflow_o <= 1'b0;
            uf_cnt_o    <= '0;
        end else if (uf_event) begin
            underflow_o <= 1'b1;
            if (uf_cnt_o != '1) begin
                uf_cnt_o <= uf_cnt_o + UfCntWidth'(1);
            end
        end
    end

endmodule
